// File: rtl/mem_access_if.sv
// Bundle between the EX/MEM stage, the load/store front-end and data_mem.
// The front-end sits on the slave modport. The pipeline/data_mem side sits on the master modport.
interface mem_access_if #(
    parameter int B = 32,
    parameter int W = 5
);
    // request from EX/MEM
    logic         valid;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   bhw;
    logic         is_unsigned;
    logic [W-1:0] addr;
    logic [B-1:0] wdata;

    // results back to the pipeline
    logic         stall;
    logic [B-1:0] rdata;
    logic         rdata_valid;
    logic         misaligned;

    // full-word port to data_mem
    logic         dm_read;
    logic         dm_write;
    logic [1:0]   dm_bhw;
    logic [W-1:0] dm_addr;
    logic [B-1:0] dm_wdata;
    logic [B-1:0] dm_rdata;

    modport slave (
        input  valid, mem_read, mem_write, bhw, is_unsigned, addr, wdata, dm_rdata,
        output stall, rdata, rdata_valid, misaligned,
               dm_read, dm_write, dm_bhw, dm_addr, dm_wdata
    );

    modport master (
        output valid, mem_read, mem_write, bhw, is_unsigned, addr, wdata, dm_rdata,
        input  stall, rdata, rdata_valid, misaligned,
               dm_read, dm_write, dm_bhw, dm_addr, dm_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store front-end: turns byte/half/word requests into aligned full-word
// data_mem accesses, with read-modify-write for sub-word stores and lane
// extraction plus sign/zero extension for loads.
//
//   state | meaning
//   IDLE  | accepting requests; word stores and misaligned flags finish here
//   LOAD  | data_mem word arrives; extract lane into rdata
//   MERGE | data_mem word arrives; write it back with the store lane replaced
module mem_access_unit #(
    parameter int B = 32,
    parameter int W = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    mem_access_if.slave bus
);

    typedef enum logic [1:0] {IDLE, LOAD, MERGE} state_t;

    state_t       state;
    logic [W-1:0] addr_q;
    logic [B-1:0] wdata_q;
    logic [1:0]   bhw_q;
    logic         uns_q;

    logic accept;
    logic is_half;
    logic is_word;
    logic mis;

    // Byte/half lane pulled down to bit 0 and extended; bhw 10/11 pass the word through.
    function automatic logic [B-1:0] extract(input logic [B-1:0] word, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
        logic [B-1:0] sh;
        logic [B-1:0] res;
        sh  = '0;
        res = word;
        case (size)
            2'b00: begin
                sh  = word >> {off, 3'b000};
                res = uns ? {{(B-8){1'b0}}, sh[7:0]} : {{(B-8){sh[7]}}, sh[7:0]};
            end
            2'b01: begin
                sh  = word >> {off[1], 4'b0000};
                res = uns ? {{(B-16){1'b0}}, sh[15:0]} : {{(B-16){sh[15]}}, sh[15:0]};
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace one byte or half lane of the fetched word with the low lanes of the store data.
    function automatic logic [B-1:0] merge(input logic [B-1:0] word, input logic [B-1:0] data,
                                           input logic [1:0] off, input logic [1:0] size);
        logic [B-1:0] mask;
        logic [B-1:0] ins;
        if (size == 2'b00) begin
            mask = {{(B-8){1'b0}}, 8'hFF} << {off, 3'b000};
            ins  = {{(B-8){1'b0}}, data[7:0]} << {off, 3'b000};
        end else begin
            mask = {{(B-16){1'b0}}, 16'hFFFF} << {off[1], 4'b0000};
            ins  = {{(B-16){1'b0}}, data[15:0]} << {off[1], 4'b0000};
        end
        return (word & ~mask) | (ins & mask);
    endfunction

    // Request decode: size class, alignment and acceptance from IDLE.
    always_comb begin
        is_half = (bus.bhw == 2'b01);
        is_word = bus.bhw[1];
        mis     = (is_half & bus.addr[0]) | (is_word & (|bus.addr[1:0]));
        accept  = bus.valid & (bus.mem_read | bus.mem_write) & (state == IDLE);
    end

    assign bus.dm_bhw = 2'b11;

    // Combinational data_mem strobes and stall; all forced low during reset.
    always_comb begin
        bus.stall    = 1'b0;
        bus.dm_read  = 1'b0;
        bus.dm_write = 1'b0;
        bus.dm_addr  = {bus.addr[W-1:2], 2'b00};
        bus.dm_wdata = bus.wdata;
        if (!i_reset) begin
            case (state)
                IDLE: begin
                    if (accept && !mis) begin
                        if (bus.mem_write && is_word) begin
                            bus.dm_write = 1'b1;
                        end else begin
                            bus.dm_read = 1'b1;
                            bus.stall   = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    bus.dm_addr = {addr_q[W-1:2], 2'b00};
                end
                MERGE: begin
                    bus.dm_addr  = {addr_q[W-1:2], 2'b00};
                    bus.dm_write = 1'b1;
                    bus.dm_wdata = merge(bus.dm_rdata, wdata_q, addr_q[1:0], bhw_q);
                end
                default: ;
            endcase
        end
    end

    // Sequencer: latch the request, step through LOAD/MERGE, register load result and flags.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= IDLE;
            bus.rdata       <= '0;
            bus.rdata_valid <= 1'b0;
            bus.misaligned  <= 1'b0;
            addr_q          <= '0;
            wdata_q         <= '0;
            bhw_q           <= 2'b00;
            uns_q           <= 1'b0;
        end else begin
            bus.rdata_valid <= 1'b0;
            bus.misaligned  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        bhw_q   <= bus.bhw;
                        uns_q   <= bus.is_unsigned;
                        if (mis) begin
                            bus.misaligned <= 1'b1;
                        end else if (bus.mem_write) begin
                            if (!is_word) state <= MERGE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    bus.rdata       <= extract(bus.dm_rdata, addr_q[1:0], bhw_q, uns_q);
                    bus.rdata_valid <= 1'b1;
                    state           <= IDLE;
                end
                MERGE:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a word-wide data_mem stand-in, a byte-array
// reference model, a vector table, hand-built corner sequences and random ops.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    mem_access_if #(.B(32), .W(5)) bus ();

    mem_access_unit #(.B(32), .W(5)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // data_mem stand-in: synchronous read, data visible the cycle after the address.
    logic [31:0] tb_mem [8];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 8; i++) tb_mem[i] <= '0;
        end else if (bus.dm_write) begin
            tb_mem[bus.dm_addr[4:2]] <= bus.dm_wdata;
        end
        bus.dm_rdata <= tb_mem[bus.dm_addr[4:2]];
    end

    // Reference model: plain byte-addressed memory.
    logic [7:0] mem_ref [32];

    function automatic int size_of(input logic [1:0] bhw);
        return (bhw == 2'b00) ? 1 : (bhw == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a - (a % 4);
        return {mem_ref[b+3], mem_ref[b+2], mem_ref[b+1], mem_ref[b]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [4:0] addr, input logic [1:0] bhw, input logic uns);
        logic [31:0] v;
        int a;
        int sz;
        a  = addr;
        sz = size_of(bhw);
        v  = 0;
        for (int i = sz - 1; i >= 0; i--) v = v * 256 + mem_ref[a+i];
        if (!uns && sz == 1 && v >= 128)   v = v + 32'hFFFFFF00;
        if (!uns && sz == 2 && v >= 32768) v = v + 32'hFFFF0000;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        bus.valid = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.bhw = 2'b11; bus.is_unsigned = 1'b0; bus.addr = '0; bus.wdata = '0;
    endtask

    // One request with a gap after it; checks cycles N, N+1, N+2 and updates the model.
    task automatic run_op(input string tag, input logic rd, input logic wr, input logic [1:0] bhw,
                          input logic uns, input logic [4:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata);
        int  sz;
        int  a;
        bit  mis, is_load, is_store, sub;
        logic [31:0] merged;
        sz = size_of(bhw);
        a  = addr;
        mis      = (a % sz) != 0;
        is_store = wr;
        is_load  = rd && !wr;
        sub      = is_store && sz < 4 && !mis;

        @(posedge clk); #1;
        bus.valid = 1'b1; bus.mem_read = rd; bus.mem_write = wr; bus.bhw = bhw;
        bus.is_unsigned = uns; bus.addr = addr; bus.wdata = wdata;
        @(negedge clk);
        chk({tag, ".stall_n"},   32'(bus.stall),    32'(!mis && (is_load || sub)));
        chk({tag, ".dread_n"},   32'(bus.dm_read),  32'(!mis && (is_load || sub)));
        chk({tag, ".dwrite_n"},  32'(bus.dm_write), 32'(is_store && !mis && sz == 4));
        if (!mis && (is_load || is_store)) begin
            chk({tag, ".daddr_n"}, 32'(bus.dm_addr), 32'(a - (a % 4)));
            chk({tag, ".dbhw_n"},  32'(bus.dm_bhw),  32'd3);
        end
        if (is_store && !mis && sz == 4) chk({tag, ".dwdata_n"}, bus.dm_wdata, wdata);

        if (is_store && !mis)
            for (int i = 0; i < sz; i++) mem_ref[a+i] = wdata[8*i +: 8];
        merged = ref_word(a);

        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk({tag, ".mis_n1"},    32'(bus.misaligned), 32'(mis));
        chk({tag, ".stall_n1"},  32'(bus.stall),      32'd0);
        chk({tag, ".dwrite_n1"}, 32'(bus.dm_write),   32'(sub));
        if (sub) chk({tag, ".merge_n1"}, bus.dm_wdata, merged);

        @(posedge clk);
        @(negedge clk);
        chk({tag, ".rvalid_n2"}, 32'(bus.rdata_valid), 32'(is_load && !mis));
        chk({tag, ".mis_n2"},    32'(bus.misaligned),  32'd0);
        if (is_load && !mis) chk({tag, ".rdata_n2"}, bus.rdata, exp_rdata);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  bhw;
        logic        uns;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [$];

    initial begin
        logic [4:0]  ra;
        logic [1:0]  rb;
        logic        rr, rw, ru;
        logic [31:0] rdv;

        for (int i = 0; i < 32; i++) mem_ref[i] = 8'h00;
        idle_inputs();

        // reset: registered outputs cleared, strobes held low even with a request present
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.mem_read = 1'b1; bus.bhw = 2'b11; bus.addr = 5'h08;
        @(negedge clk);
        chk("rst.stall",  32'(bus.stall),       32'd0);
        chk("rst.dread",  32'(bus.dm_read),     32'd0);
        chk("rst.dwrite", 32'(bus.dm_write),    32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("rst.rdata",  bus.rdata,            32'd0);
        chk("rst.rvalid", 32'(bus.rdata_valid), 32'd0);
        chk("rst.mis",    32'(bus.misaligned),  32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_clr = 1'b0;

        //                rd    wr    bhw    uns   addr   wdata          exp_rdata
        vecs.push_back('{1'b0, 1'b1, 2'b11, 1'b0, 5'h08, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 1'b0, 5'h08, 32'h0,        32'hDEADBEEF});
        vecs.push_back('{1'b0, 1'b1, 2'b11, 1'b0, 5'h08, 32'h11223344, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 5'h09, 32'h000000A5, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 1'b0, 5'h08, 32'h0,        32'h1122A544});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b0, 5'h09, 32'h0,        32'hFFFFFFA5});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b1, 5'h09, 32'h0,        32'h000000A5});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 5'h0A, 32'h00008001, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 1'b0, 5'h08, 32'h0,        32'h8001A544});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b0, 5'h0A, 32'h0,        32'hFFFF8001});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b1, 5'h0A, 32'h0,        32'h00008001});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 1'b0, 5'h06, 32'h0,        32'h0});
        vecs.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 5'h05, 32'h0000BEEF, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 2'b11, 1'b0, 5'h08, 32'h0,        32'h8001A544});
        vecs.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 5'h10, 32'hCAFEF00D, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b1, 5'h10, 32'h0,        32'hCAFEF00D});
        vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b0, 5'h13, 32'h0,        32'hFFFFFFCA});
        vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b1, 5'h10, 32'h0,        32'h0000F00D});

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].bhw, vecs[i].uns,
                   vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // no valid, or valid without read/write: nothing happens
        @(posedge clk); #1;
        bus.valid = 1'b0; bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.addr = 5'h08;
        @(negedge clk);
        chk("novalid.stall",  32'(bus.stall),    32'd0);
        chk("novalid.dread",  32'(bus.dm_read),  32'd0);
        chk("novalid.dwrite", 32'(bus.dm_write), 32'd0);
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        @(negedge clk);
        chk("noop.stall",  32'(bus.stall),    32'd0);
        chk("noop.dread",  32'(bus.dm_read),  32'd0);
        chk("noop.dwrite", 32'(bus.dm_write), 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("noop.rvalid", 32'(bus.rdata_valid), 32'd0);
        chk("noop.mis",    32'(bus.misaligned),  32'd0);

        // reset while in MERGE: write dropped, word unchanged, rdata cleared
        run_op("rstm.pre", 1'b0, 1'b1, 2'b11, 1'b0, 5'h14, 32'h55667788, 32'h0);
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.mem_write = 1'b1; bus.bhw = 2'b00; bus.addr = 5'h15; bus.wdata = 32'hEE;
        @(negedge clk);
        chk("rstm.stall_n", 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        chk("rstm.dwrite", 32'(bus.dm_write), 32'd0);
        chk("rstm.stall",  32'(bus.stall),    32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstm.stall_after",  32'(bus.stall),    32'd0);
        chk("rstm.dwrite_after", 32'(bus.dm_write), 32'd0);
        chk("rstm.rdata_clr",    bus.rdata,         32'd0);
        chk("rstm.mem",          tb_mem[5],         32'h55667788);
        run_op("rstm.lw", 1'b1, 1'b0, 2'b11, 1'b0, 5'h14, 32'h0, 32'h55667788);

        // SB then LB with no gap: LB held one cycle, then sees merged byte
        @(posedge clk); #1;
        bus.valid = 1'b1; bus.mem_write = 1'b1; bus.bhw = 2'b00; bus.addr = 5'h0C; bus.wdata = 32'h7F;
        @(negedge clk);
        chk("b2b.stall_n", 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        bus.mem_write = 1'b0; bus.mem_read = 1'b1; bus.wdata = 32'h0;
        @(negedge clk);
        chk("b2b.dwrite_n1", 32'(bus.dm_write),      32'd1);
        chk("b2b.dread_n1",  32'(bus.dm_read),       32'd0);
        chk("b2b.stall_n1",  32'(bus.stall),         32'd0);
        chk("b2b.byte_n1",   32'(bus.dm_wdata[7:0]), 32'h7F);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b.dread_n2", 32'(bus.dm_read), 32'd1);
        chk("b2b.stall_n2", 32'(bus.stall),   32'd1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("b2b.rvalid_n3", 32'(bus.rdata_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b.rvalid_n4", 32'(bus.rdata_valid), 32'd1);
        chk("b2b.rdata_n4",  bus.rdata,            32'h0000007F);
        mem_ref[12] = 8'h7F;
        @(posedge clk);
        @(negedge clk);
        chk("b2b.rvalid_hold", 32'(bus.rdata_valid), 32'd0);
        chk("b2b.rdata_hold",  bus.rdata,            32'h0000007F);

        // random traffic against the byte model
        for (int i = 0; i < 200; i++) begin
            ra  = 5'($urandom_range(0, 31));
            rb  = 2'($urandom_range(0, 3));
            rr  = 1'($urandom_range(0, 1));
            rw  = 1'($urandom_range(0, 1));
            ru  = 1'($urandom_range(0, 1));
            rdv = $urandom;
            if (!rr && !rw) rr = 1'b1;
            run_op($sformatf("rnd%0d", i), rr, rw, rb, ru, ra, rdv, ref_load(ra, rb, ru));
        end

        // final sweep of every word
        for (int w = 0; w < 8; w++)
            run_op($sformatf("sweep%0d", w), 1'b1, 1'b0, 2'b11, 1'b0, 5'(w * 4), 32'h0,
                   ref_load(5'(w * 4), 2'b11, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
